// File: rtl/positron_sched_pkg.sv
// Shared types and posit helpers for the inter-layer positron scheduler.
// Signed-integer ordering of posit words; NaR is the most negative code.
package positron_sched_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } serializer_state_t;

  function automatic logic posit_gt(
    input logic signed [63:0] a,
    input logic signed [63:0] b
  );
    return a > b;
  endfunction

  function automatic logic [63:0] posit_nar(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/posit_argmax_tracker.sv
// Running argmax over one streamed frame of posit words.
// Built only when LAYER_SERIALIZER_ARGMAX_EN is defined.
`ifdef LAYER_SERIALIZER_ARGMAX_EN
module posit_argmax_tracker
  import positron_sched_pkg::*;
#(
  parameter int POSIT_WIDTH = 16,
  parameter int IDX_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid,
  input  logic                   sow,
  input  logic                   eow,
  input  logic [POSIT_WIDTH-1:0] posit,
  input  logic [IDX_W-1:0]       idx,
  output logic [IDX_W-1:0]       argmax_o,
  output logic                   argmax_valid_o
);

  localparam logic [POSIT_WIDTH-1:0] NAR =
    POSIT_WIDTH'(posit_nar(POSIT_WIDTH));

  logic [POSIT_WIDTH-1:0] max_q;
  logic [IDX_W-1:0]       max_idx_q;
  logic signed [63:0]     cur_s;
  logic signed [63:0]     max_s;
  logic                   win;
  logic [IDX_W-1:0]       win_idx;

  assign cur_s = 64'($signed(posit));
  assign max_s = 64'($signed(max_q));

  // Strict compare keeps the lower index on ties
  always_comb begin
    win     = sow | ((posit != NAR) & posit_gt(cur_s, max_s));
    win_idx = win ? idx : max_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q          <= '0;
      max_idx_q      <= '0;
      argmax_o       <= '0;
      argmax_valid_o <= 1'b0;
    end else begin
      argmax_valid_o <= valid & eow;
      if (valid && win) begin
        max_q     <= posit;
        max_idx_q <= idx;
      end
      if (valid && eow) argmax_o <= win_idx;
    end
  end

endmodule
`endif

// File: rtl/positron_layer_serializer.sv
// Collects one result per positron, then streams them as one framed window.
// Optional argmax tracking under LAYER_SERIALIZER_ARGMAX_EN.
module positron_layer_serializer
  import positron_sched_pkg::*;
#(
  parameter int POSIT_WIDTH  = 16,
  parameter int NB_POSITRONS = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NB_POSITRONS-1:0]             rts_i,
  input  logic [NB_POSITRONS-1:0]             eow_i,
  input  logic [NB_POSITRONS*POSIT_WIDTH-1:0] posit_i,
  output logic [NB_POSITRONS-1:0]             rtr_o,
  input  logic                                rtr_i,
  output logic                                rts_o,
  output logic                                sow_o,
  output logic                                eow_o,
  output logic [POSIT_WIDTH-1:0]              posit_o,
  output logic [$clog2(NB_POSITRONS)-1:0]     argmax_o,
  output logic                                argmax_valid_o
);

  localparam int IW = $clog2(NB_POSITRONS);
  localparam logic [IW-1:0] LAST = IW'(NB_POSITRONS - 1);

  serializer_state_t       state_q, state_d;
  logic [NB_POSITRONS-1:0] got_q, got_d;
  logic [NB_POSITRONS-1:0] cap;
  logic [IW-1:0]           rd_idx_q, rd_idx_d;
  logic [POSIT_WIDTH-1:0]  buf_q [NB_POSITRONS];
  logic                    hs;

  assign cap = rts_i & eow_i & rtr_o;
  assign hs  = rts_o & rtr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      got_q    <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      got_q    <= got_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Result storage needs no reset; got_q qualifies its contents
  always_ff @(posedge clk) begin
    for (int k = 0; k < NB_POSITRONS; k++) begin
      if (cap[k]) buf_q[k] <= posit_i[k*POSIT_WIDTH +: POSIT_WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    got_d    = got_q | cap;
    rd_idx_d = rd_idx_q;
    unique case (state_q)
      COLLECT: begin
        if (&got_d) state_d = DRAIN;
      end
      DRAIN: begin
        if (hs) begin
          if (rd_idx_q == LAST) begin
            rd_idx_d = '0;
            got_d    = '0;
            state_d  = COLLECT;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    rtr_o   = '0;
    rts_o   = 1'b0;
    sow_o   = 1'b0;
    eow_o   = 1'b0;
    posit_o = '0;
    if (state_q == COLLECT) begin
      rtr_o = ~got_q;
    end else begin
      rts_o   = 1'b1;
      sow_o   = (rd_idx_q == '0);
      eow_o   = (rd_idx_q == LAST);
      posit_o = buf_q[rd_idx_q];
    end
  end

`ifdef LAYER_SERIALIZER_ARGMAX_EN
  posit_argmax_tracker #(
    .POSIT_WIDTH(POSIT_WIDTH),
    .IDX_W      (IW)
  ) u_argmax (
    .clk           (clk),
    .rst           (rst),
    .valid         (hs),
    .sow           (sow_o),
    .eow           (eow_o),
    .posit         (posit_o),
    .idx           (rd_idx_q),
    .argmax_o      (argmax_o),
    .argmax_valid_o(argmax_valid_o)
  );
`else
  assign argmax_o       = '0;
  assign argmax_valid_o = 1'b0;
`endif

endmodule
